// File: rtl/ireg_skew_border_pkg.sv
// Shared constants and helpers for the skewed border input register array.
// Legal parameter ranges live here so every block checks against the same limits.
package ireg_skew_border_pkg;

  localparam int CH_MIN       = 1;
  localparam int CH_MAX       = 64;
  localparam int BASE_DLY_MIN = 1;
  localparam int BASE_DLY_MAX = 16;
  localparam int DEPTH_MAX    = BASE_DLY_MAX + CH_MAX - 1;

  function automatic bit ch_legal(input int ch);
    return (ch >= CH_MIN) && (ch <= CH_MAX);
  endfunction

  function automatic bit base_dly_legal(input int dly);
    return (dly >= BASE_DLY_MIN) && (dly <= BASE_DLY_MAX);
  endfunction

  // Bits occupied by one {valid, data} stage of the given data width.
  function automatic int stage_bits(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/ireg_delay_line.sv
// Single-channel delay chain of {valid, data} stages with hold and synchronous clear.
// Every stage is exposed so the parent can choose its tap combinationally.
module ireg_delay_line
  import ireg_skew_border_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_data,
  output logic [DEPTH-1:0]        o_valid,
  output logic [DEPTH*WIDTH-1:0]  o_data
);

  typedef struct packed {
    logic                    valid;
    logic signed [WIDTH-1:0] data;
  } stage_t;

  if ((DEPTH < 1) || (DEPTH > DEPTH_MAX)) begin : g_bad_depth
    $fatal(1, "ireg_delay_line: DEPTH out of range");
  end
  if ($bits(stage_t) != stage_bits(WIDTH)) begin : g_bad_stage
    $fatal(1, "ireg_delay_line: stage layout mismatch");
  end

  stage_t [DEPTH-1:0] r_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else if (clr) begin
      r_stage <= '0;
    end else if (en) begin
      // Invalid inputs enter as zero so the array edge sees zero padding.
      r_stage[0] <= '{valid: i_valid, data: (i_valid ? i_data : '0)};
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  always_comb begin
    o_valid = '0;
    o_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_valid[i]               = r_stage[i].valid;
      o_data[i*WIDTH +: WIDTH] = r_stage[i].data;
    end
  end

endmodule

// File: rtl/ireg_skew_border.sv
// Border input register bank: channel c is delayed BASE_DLY+c cycles in skew mode,
// or BASE_DLY cycles in aligned mode, forming the diagonal wavefront for a systolic array.
module ireg_skew_border
  import ireg_skew_border_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CH       = 4,
  parameter int BASE_DLY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  skew_en,
  input  logic [CH-1:0]         i_valid,
  input  logic [CH*WIDTH-1:0]   i_data,
  output logic [CH-1:0]         o_valid,
  output logic [CH*WIDTH-1:0]   o_data,
  output logic                  o_busy
);

  if (!ch_legal(CH)) begin : g_bad_ch
    $fatal(1, "ireg_skew_border: CH must be in 1..64");
  end
  if (!base_dly_legal(BASE_DLY)) begin : g_bad_dly
    $fatal(1, "ireg_skew_border: BASE_DLY must be in 1..16");
  end

  logic [CH-1:0] w_busy;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    localparam int DEPTH     = BASE_DLY + c;
    localparam int SKEW_TAP  = DEPTH - 1;
    localparam int ALIGN_TAP = BASE_DLY - 1;

    logic [DEPTH-1:0]       w_stage_valid;
    logic [DEPTH*WIDTH-1:0] w_stage_data;

    ireg_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_line (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .clr     (clr),
      .i_valid (i_valid[c]),
      .i_data  (i_data[c*WIDTH +: WIDTH]),
      .o_valid (w_stage_valid),
      .o_data  (w_stage_data)
    );

    // Tap choice is purely combinational; tokens beyond the chosen tap are simply ignored.
    assign o_valid[c] = skew_en ? w_stage_valid[SKEW_TAP] : w_stage_valid[ALIGN_TAP];
    assign o_data[c*WIDTH +: WIDTH] = skew_en ? w_stage_data[SKEW_TAP*WIDTH +: WIDTH]
                                              : w_stage_data[ALIGN_TAP*WIDTH +: WIDTH];
    assign w_busy[c] = |w_stage_valid;
  end

  assign o_busy = |w_busy;

endmodule

// File: tb/tb_ireg_skew_border.sv
// Directed, table-driven bench for ireg_skew_border at CH=4, WIDTH=8, BASE_DLY=1.
module tb_ireg_skew_border;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic        skew_en;
  logic [3:0]  i_valid;
  logic [31:0] i_data;
  logic [3:0]  o_valid;
  logic [31:0] o_data;
  logic        o_busy;

  int checks;
  int failures;

  ireg_skew_border #(
    .WIDTH    (8),
    .CH       (4),
    .BASE_DLY (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .skew_en (skew_en),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        clr;
    logic        skew;
    logic [3:0]  vld;
    logic [31:0] data;
    logic [3:0]  exp_vld;
    logic [31:0] exp_data;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic c, input logic s, input logic [3:0] v,
                              input logic [31:0] d, input logic [3:0] ev,
                              input logic [31:0] ed, input logic eb);
    vec_t t;
    t.en = e; t.clr = c; t.skew = s; t.vld = v; t.data = d;
    t.exp_vld = ev; t.exp_data = ed; t.exp_busy = eb;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ev, input logic [31:0] ed,
                           input logic eb);
    check({tag, ".valid"}, {28'd0, o_valid}, {28'd0, ev});
    check({tag, ".data"}, o_data, ed);
    check({tag, ".busy"}, {31'd0, o_busy}, {31'd0, eb});
  endtask

  task automatic drive(input logic e, input logic c, input logic s, input logic [3:0] v,
                       input logic [31:0] d);
    en = e; clr = c; skew_en = s; i_valid = v; i_data = d;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 4'h0, 32'h0);

    // Skew wavefront: {4,3,2,1} leaves one channel per cycle.
    vecs.push_back(mk(1, 0, 1, 4'hF, 32'h04030201, 4'b0001, 32'h00000001, 1));
    vecs.push_back(mk(1, 0, 1, 4'h0, 32'h00000000, 4'b0010, 32'h00000200, 1));
    vecs.push_back(mk(1, 0, 1, 4'h0, 32'h00000000, 4'b0100, 32'h00030000, 1));
    vecs.push_back(mk(1, 0, 1, 4'h0, 32'h00000000, 4'b1000, 32'h04000000, 1));
    vecs.push_back(mk(1, 0, 1, 4'h0, 32'h00000000, 4'b0000, 32'h00000000, 0));
    // Aligned: all four at once; leftover tokens drain past the tap unseen.
    vecs.push_back(mk(1, 0, 0, 4'hF, 32'h04030201, 4'b1111, 32'h04030201, 1));
    vecs.push_back(mk(1, 0, 0, 4'h0, 32'h00000000, 4'b0000, 32'h00000000, 1));
    vecs.push_back(mk(1, 0, 0, 4'h0, 32'h00000000, 4'b0000, 32'h00000000, 1));
    vecs.push_back(mk(1, 0, 0, 4'h0, 32'h00000000, 4'b0000, 32'h00000000, 1));
    vecs.push_back(mk(1, 0, 0, 4'h0, 32'h00000000, 4'b0000, 32'h00000000, 0));
    // Zero insertion: invalid 0xFF data never appears.
    vecs.push_back(mk(1, 0, 0, 4'h0, 32'hFFFFFFFF, 4'b0000, 32'h00000000, 0));
    vecs.push_back(mk(1, 0, 1, 4'h0, 32'hFFFFFFFF, 4'b0000, 32'h00000000, 0));
    // Stall: ch3 = -5, two enabled edges, three held, two more enabled.
    vecs.push_back(mk(1, 0, 1, 4'h8, 32'hFB000000, 4'b0000, 32'h00000000, 1));
    vecs.push_back(mk(1, 0, 1, 4'h0, 32'h00000000, 4'b0000, 32'h00000000, 1));
    vecs.push_back(mk(0, 0, 1, 4'hF, 32'h11223344, 4'b0000, 32'h00000000, 1));
    vecs.push_back(mk(0, 0, 1, 4'hF, 32'h11223344, 4'b0000, 32'h00000000, 1));
    vecs.push_back(mk(0, 0, 1, 4'hF, 32'h11223344, 4'b0000, 32'h00000000, 1));
    vecs.push_back(mk(1, 0, 1, 4'h0, 32'h00000000, 4'b0000, 32'h00000000, 1));
    vecs.push_back(mk(1, 0, 1, 4'h0, 32'h00000000, 4'b1000, 32'hFB000000, 1));
    vecs.push_back(mk(1, 0, 1, 4'h0, 32'h00000000, 4'b0000, 32'h00000000, 0));
    // Clear with en low, then clear overriding en high.
    vecs.push_back(mk(1, 0, 1, 4'hF, 32'h04030201, 4'b0001, 32'h00000001, 1));
    vecs.push_back(mk(0, 1, 1, 4'hF, 32'h04030201, 4'b0000, 32'h00000000, 0));
    vecs.push_back(mk(1, 0, 1, 4'hF, 32'h84838281, 4'b0001, 32'h00000081, 1));
    vecs.push_back(mk(1, 1, 1, 4'hF, 32'h84838281, 4'b0000, 32'h00000000, 0));

    #2;
    check_all("reset", 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].clr, vecs[i].skew, vecs[i].vld, vecs[i].data);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_data, vecs[i].exp_busy);
    end

    // Mode switch takes effect without a clock edge.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 4'hF, 32'h04030201);
    @(posedge clk);
    #1;
    check_all("mode_skew", 4'b0001, 32'h00000001, 1'b1);
    skew_en = 1'b0;
    #1;
    check_all("mode_align", 4'b1111, 32'h04030201, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    check_all("mode_clr", 4'h0, 32'h0, 1'b0);

    // Asynchronous reset between edges with tokens in flight.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 4'hF, 32'h04030201);
    @(posedge clk);
    #1;
    check_all("pre_rst", 4'b0001, 32'h00000001, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 4'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 4'hF, 32'h08070605);
    @(posedge clk);
    #1;
    check_all("post_rst0", 4'b0001, 32'h00000005, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    check_all("post_rst1", 4'b0010, 32'h00000600, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
